half_duplex_xcvr_ctrl: RTL and testbench

Multi-channel direction controller for half-duplex line transceivers (RS-485 class) sitting between the UART outputs of `sonata_system` and the transceiver pins at the top level. It generalises single-channel RS-485 control to `NumCh` channels with a per-channel half/full-duplex mode. It adds a data delay line so no transmitted bits are lost while the driver turns on, an explicit receiver guard period after turnaround, and per-channel busy status.

---
 rtl/half_duplex_xcvr_ctrl_pkg.sv | 47 ++++
 rtl/half_duplex_xcvr_chan.sv | 166 ++++++++++++++++
 rtl/half_duplex_xcvr_ctrl.sv | 44 ++++
 tb/tb_half_duplex_xcvr_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/half_duplex_xcvr_ctrl_pkg.sv
// Shared types and helpers for the half-duplex transceiver direction controller.
// State encoding plus the output decode used by every channel FSM.
package half_duplex_xcvr_ctrl_pkg;

   typedef enum logic [2:0] {
      XCVR_RX_OFF  = 3'd0,
      XCVR_RX_ON   = 3'd1,
      XCVR_TX_TURN = 3'd2,
      XCVR_TX      = 3'd3,
      XCVR_TX_END  = 3'd4,
      XCVR_GUARD   = 3'd5
   } xcvr_state_e;

   // Counter must hold the longest load (S+E) with headroom; it never wraps.
   function automatic int unsigned xcvr_cnt_width(input int unsigned switch_cycles,
                                                  input int unsigned end_cycles);
      return $clog2(switch_cycles + end_cycles + 2);
   endfunction

   function automatic logic xcvr_drives_line(input xcvr_state_e st);
      logic r;
      case (st)
         XCVR_TX_TURN, XCVR_TX, XCVR_TX_END: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic xcvr_listening(input xcvr_state_e st);
      logic r;
      case (st)
         XCVR_RX_ON: r = 1'b1;
         default:    r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic xcvr_busy(input xcvr_state_e st);
      logic r;
      case (st)
         XCVR_RX_OFF, XCVR_RX_ON: r = 1'b0;
         default:                 r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/half_duplex_xcvr_chan.sv
// One transceiver channel: turnaround FSM, down-counter and TX data delay line,
// or a registered pass-through when the channel is strapped full-duplex.
module half_duplex_xcvr_chan
   import half_duplex_xcvr_ctrl_pkg::*;
#(
   parameter int unsigned SwitchCycles = 5,
   parameter int unsigned EndCycles    = 5,
   parameter bit          FullDuplex   = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic tx_i,
   input  logic tx_enable_i,
   input  logic rx_enable_i,
   input  logic ro_i,
   output logic rx_o,
   output logic di_o,
   output logic de_o,
   output logic ren_o,
   output logic busy_o
);

   if (FullDuplex) begin : g_full
      logic de_q, de_d;
      logic ren_q, ren_d;
      logic di_q, di_d;

      always_comb begin
         de_d  = tx_enable_i;
         ren_d = ~rx_enable_i;
         di_d  = tx_i;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            de_q  <= 1'b0;
            ren_q <= 1'b1;
            di_q  <= 1'b1;
         end else begin
            de_q  <= de_d;
            ren_q <= ren_d;
            di_q  <= di_d;
         end
      end

      assign de_o   = de_q;
      assign ren_o  = ren_q;
      assign di_o   = di_q;
      assign rx_o   = rx_enable_i ? ro_i : 1'b1;
      assign busy_o = 1'b0;
   end else begin : g_half
      localparam int unsigned DlyLen = SwitchCycles + 1;
      localparam int unsigned CntW   = xcvr_cnt_width(SwitchCycles, EndCycles);
      localparam logic [CntW-1:0] TurnLoad = CntW'(SwitchCycles - 1);
      localparam logic [CntW-1:0] EndLoad  = CntW'(SwitchCycles + EndCycles);
      localparam logic [CntW-1:0] CntOne   = CntW'(1);
      localparam logic [CntW-1:0] CntZero  = CntW'(0);

      xcvr_state_e       state_q, state_d;
      logic [CntW-1:0]   cnt_q, cnt_d;
      logic [DlyLen-1:0] dly_q, dly_d;
      logic              de_q, de_d;
      logic              ren_q, ren_d;
      logic              busy_q, busy_d;
      logic              listen_q, listen_d;
      logic              cnt_zero;

      assign cnt_zero = (cnt_q == CntZero);

      // Each timed state loads the counter on entry and leaves when it reaches zero.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         case (state_q)
            XCVR_RX_OFF, XCVR_RX_ON: begin
               if (tx_enable_i) begin
                  state_d = XCVR_TX_TURN;
                  cnt_d   = TurnLoad;
               end else if (rx_enable_i) begin
                  state_d = XCVR_RX_ON;
               end else begin
                  state_d = XCVR_RX_OFF;
               end
            end
            XCVR_TX_TURN: begin
               if (cnt_zero) begin
                  state_d = XCVR_TX;
               end else begin
                  cnt_d = cnt_q - CntOne;
               end
            end
            XCVR_TX: begin
               if (!tx_enable_i) begin
                  state_d = XCVR_TX_END;
                  cnt_d   = EndLoad;
               end else begin
                  state_d = XCVR_TX;
               end
            end
            XCVR_TX_END: begin
               // Re-request while draining: the driver is still on, resume directly.
               if (tx_enable_i) begin
                  state_d = XCVR_TX;
                  cnt_d   = CntZero;
               end else if (cnt_zero) begin
                  state_d = XCVR_GUARD;
                  cnt_d   = TurnLoad;
               end else begin
                  cnt_d = cnt_q - CntOne;
               end
            end
            XCVR_GUARD: begin
               if (!cnt_zero) begin
                  cnt_d = cnt_q - CntOne;
               end else if (tx_enable_i) begin
                  state_d = XCVR_TX_TURN;
                  cnt_d   = TurnLoad;
               end else if (rx_enable_i) begin
                  state_d = XCVR_RX_ON;
               end else begin
                  state_d = XCVR_RX_OFF;
               end
            end
            default: begin
               state_d = XCVR_RX_OFF;
               cnt_d   = CntZero;
            end
         endcase
      end

      always_comb begin
         dly_d    = {dly_q[DlyLen-2:0], tx_i};
         de_d     = xcvr_drives_line(state_d);
         ren_d    = ~xcvr_listening(state_d);
         busy_d   = xcvr_busy(state_d);
         listen_d = xcvr_listening(state_d);
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            state_q  <= XCVR_RX_OFF;
            cnt_q    <= CntZero;
            dly_q    <= {DlyLen{1'b1}};
            de_q     <= 1'b0;
            ren_q    <= 1'b1;
            busy_q   <= 1'b0;
            listen_q <= 1'b0;
         end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dly_q    <= dly_d;
            de_q     <= de_d;
            ren_q    <= ren_d;
            busy_q   <= busy_d;
            listen_q <= listen_d;
         end
      end

      assign de_o   = de_q;
      assign ren_o  = ren_q;
      assign busy_o = busy_q;
      assign di_o   = dly_q[DlyLen-1];
      assign rx_o   = listen_q ? ro_i : 1'b1;
   end

endmodule

// File: rtl/half_duplex_xcvr_ctrl.sv
// Multi-channel RS-485 direction controller: one independent channel per
// UART, each either half-duplex with turnaround control or full-duplex bypass.
module half_duplex_xcvr_ctrl
   import half_duplex_xcvr_ctrl_pkg::*;
#(
   parameter int unsigned      NumCh        = 2,
   parameter int unsigned      SwitchCycles = 5,
   parameter int unsigned      EndCycles    = 5,
   parameter logic [NumCh-1:0] FullDuplex   = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [NumCh-1:0] tx_i,
   input  logic [NumCh-1:0] tx_enable_i,
   input  logic [NumCh-1:0] rx_enable_i,
   output logic [NumCh-1:0] rx_o,
   output logic [NumCh-1:0] di_o,
   output logic [NumCh-1:0] de_o,
   output logic [NumCh-1:0] ren_o,
   input  logic [NumCh-1:0] ro_i,
   output logic [NumCh-1:0] busy_o
);

   for (genvar ch = 0; ch < NumCh; ch++) begin : g_ch
      half_duplex_xcvr_chan #(
         .SwitchCycles (SwitchCycles),
         .EndCycles    (EndCycles),
         .FullDuplex   (FullDuplex[ch])
      ) u_chan (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .tx_i        (tx_i[ch]),
         .tx_enable_i (tx_enable_i[ch]),
         .rx_enable_i (rx_enable_i[ch]),
         .ro_i        (ro_i[ch]),
         .rx_o        (rx_o[ch]),
         .di_o        (di_o[ch]),
         .de_o        (de_o[ch]),
         .ren_o       (ren_o[ch]),
         .busy_o      (busy_o[ch])
      );
   end

endmodule

// File: tb/tb_half_duplex_xcvr_ctrl.sv
// Directed bench: ch0 half-duplex turnarounds with timing taken from S=5, E=5,
// ch1 full-duplex with random traffic; expectations queued with a due cycle.
module tb_half_duplex_xcvr_ctrl;

   typedef enum int {SIG_DE, SIG_REN, SIG_DI, SIG_RX, SIG_BUSY} sig_e;
   typedef struct {
      int   due;
      int   ch;
      sig_e sig;
      logic val;
      int   ph;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic [1:0] tx_i, tx_enable_i, rx_enable_i, ro_i;
   logic [1:0] rx_o, di_o, de_o, ren_o, busy_o;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic hist [0:511];
   exp_t q [$];

   always #5 clk = ~clk;

   half_duplex_xcvr_ctrl #(
      .NumCh        (2),
      .SwitchCycles (5),
      .EndCycles    (5),
      .FullDuplex   (2'b10)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .tx_i        (tx_i),
      .tx_enable_i (tx_enable_i),
      .rx_enable_i (rx_enable_i),
      .rx_o        (rx_o),
      .di_o        (di_o),
      .de_o        (de_o),
      .ren_o       (ren_o),
      .ro_i        (ro_i),
      .busy_o      (busy_o)
   );

   function automatic logic obs(input int ch, input sig_e s);
      logic r;
      case (s)
         SIG_DE:   r = de_o[ch];
         SIG_REN:  r = ren_o[ch];
         SIG_DI:   r = di_o[ch];
         SIG_RX:   r = rx_o[ch];
         SIG_BUSY: r = busy_o[ch];
         default:  r = 1'bx;
      endcase
      return r;
   endfunction

   task automatic compare(input int ph, input int ch, input sig_e s, input logic want);
      logic got;
      got = obs(ch, s);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL p%0d_ch%0d_%s cyc %0d: observed %b expected %b",
                ph, ch, s.name(), cyc, got, want);
      end
   endtask

   task automatic push(input int due, input int ch, input sig_e s, input logic v, input int ph);
      exp_t e;
      e.due = due; e.ch = ch; e.sig = s; e.val = v; e.ph = ph;
      q.push_back(e);
   endtask

   // Compare everything due this cycle at the falling edge, then move to the next cycle.
   task automatic cycle_end();
      @(negedge clk);
      for (int k = q.size() - 1; k >= 0; k--) begin
         if (q[k].due == cyc) begin
            compare(q[k].ph, q[k].ch, q[k].sig, q[k].val);
            q.delete(k);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive_fd();
      logic te, re, t, r;
      te = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      t  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      tx_enable_i[1] = te;
      rx_enable_i[1] = re;
      tx_i[1]        = t;
      ro_i[1]        = r;
      push(cyc + 1, 1, SIG_DE, te, 5);
      push(cyc + 1, 1, SIG_REN, ~re, 5);
      push(cyc + 1, 1, SIG_DI, t, 5);
      push(cyc, 1, SIG_RX, re ? r : 1'b1, 5);
      push(cyc, 1, SIG_BUSY, 1'b0, 5);
   endtask

   // Drive ch0 for this cycle and queue the outputs the spec timing predicts for it.
   task automatic step0(input logic te, input logic re, input logic t, input logic r,
                        input logic de, input logic busy, input logic rxon, input int ph);
      tx_enable_i[0] = te;
      rx_enable_i[0] = re;
      tx_i[0]        = t;
      ro_i[0]        = r;
      hist[cyc]      = t;
      push(cyc, 0, SIG_DE, de, ph);
      push(cyc, 0, SIG_BUSY, busy, ph);
      push(cyc, 0, SIG_REN, ~rxon, ph);
      push(cyc, 0, SIG_RX, rxon ? r : 1'b1, ph);
      push(cyc, 0, SIG_DI, (cyc >= 6) ? hist[cyc - 6] : 1'b1, ph);
      drive_fd();
      cycle_end();
   endtask

   task automatic check_reset_values(input int ph);
      for (int ch = 0; ch < 2; ch++) begin
         compare(ph, ch, SIG_DE, 1'b0);
         compare(ph, ch, SIG_REN, 1'b1);
         compare(ph, ch, SIG_DI, 1'b1);
         compare(ph, ch, SIG_RX, 1'b1);
         compare(ph, ch, SIG_BUSY, 1'b0);
      end
   endtask

   initial begin
      rst_ni      = 1'b0;
      tx_i        = 2'b00;
      tx_enable_i = 2'b00;
      rx_enable_i = 2'b00;
      ro_i        = 2'b00;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_reset_values(0);
      rst_ni = 1'b1;
      #1;
      check_reset_values(0);
      tx_i = 2'b11;

      // Idle: RX_OFF, then receiver enabled.
      for (int i = 0; i < 6; i++)
         step0(1'b0, i >= 3, 1'b1, 1'(i % 2), 1'b0, 1'b0, i >= 4, 6);

      // Basic turnaround with 0,1,0,0 on tx_i, receiver requested throughout.
      for (int i = 0; i < 40; i++)
         step0(i < 20, 1'b1, (i == 1) || (i >= 4), 1'(i % 2),
               (i >= 1) && (i <= 31), (i >= 1) && (i <= 36), (i == 0) || (i >= 37), 1);

      // Re-request at cycle 25 while draining in TX_END.
      for (int i = 0; i < 51; i++)
         step0((i < 20) || ((i >= 25) && (i < 31)), 1'b1, 1'($urandom_range(0, 1)),
               1'((i + 1) % 2), (i >= 1) && (i <= 42), (i >= 1) && (i <= 47),
               (i == 0) || (i >= 48), 2);

      // Request arrives two cycles into GUARD and waits for it to finish.
      for (int i = 0; i < 53; i++)
         step0((i < 10) || ((i >= 24) && (i < 33)), 1'b1, 1'($urandom_range(0, 1)),
               1'(i % 2), ((i >= 1) && (i <= 21)) || ((i >= 27) && (i <= 44)),
               (i >= 1) && (i <= 49), (i == 0) || (i >= 50), 3);

      // Fill the delay line with zeros, then reset asynchronously mid-cycle.
      for (int i = 0; i < 8; i++)
         step0(1'b1, 1'b1, 1'b0, 1'(i % 2), i >= 1, i >= 1, i == 0, 4);
      tx_enable_i = 2'b00;
      rx_enable_i = 2'b00;
      ro_i        = 2'b00;
      tx_i        = 2'b00;
      #1;
      rst_ni = 1'b0;
      #1;
      check_reset_values(7);
      q.delete();
      rst_ni = 1'b1;
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
